fetch_controller: RTL and testbench

Instruction-fetch sequencer between the byte-addressed instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues one word request at a time over a req/ready handshake. Returned words go into a small prefetch buffer, so memory latency and downstream freezes are decoupled. Taken branches redirect fetch; wrong-path words, including a response still in flight, are discarded.

---
 rtl/fetch_controller_pkg.sv | 18 +
 rtl/fetch_controller_buffer.sv | 49 ++++
 rtl/fetch_controller.sv | 81 ++++++++
 tb/tb_fetch_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_controller_pkg;

  typedef enum logic {StRun, StDrain} fc_state_e;

  localparam int unsigned WordBytes      = 4;
  localparam logic [31:0] DefaultResetPc = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_buffer.sv
// Prefetch FIFO of {address, word} pairs; flush beats push, push+pop legal when full.
module fetch_controller_buffer
  import fetch_controller_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_entry,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [AddrW:0] r_wptr;
  logic [AddrW:0] r_rptr;
  fetch_entry_t   r_mem [Depth];
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                   (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
  assign o_head  = r_mem[r_rptr[AddrW-1:0]];
  assign w_push  = i_push && (!o_full || i_pop);
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  // When full, the write slot is the head being popped this cycle, so overwriting is safe.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr[AddrW-1:0]] <= i_entry;
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the fetch PC, issues word requests, buffers returns, handles redirects.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] RESET_PC  = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        mem_req,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_instruction,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  fc_state_e    r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_stale_addr;
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_run;
  logic         w_pop;
  logic         w_push;

  assign w_run = (r_state == StRun);
  assign valid = !w_empty;
  assign w_pop = valid && !freeze;

  // DRAIN keeps the stale request up until memory completes it.
  assign mem_req     = !rst && (w_run ? (!w_full || w_pop) : 1'b1);
  assign mem_address = rst ? RESET_PC : (w_run ? r_fetch_pc : r_stale_addr);
  assign w_push      = w_run && mem_req && mem_ready && !branch_taken;

  fetch_controller_buffer #(
    .Depth (BUF_DEPTH)
  ) u_buffer (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (branch_taken),
    .i_entry ({mem_address, mem_instruction}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StRun;
      r_fetch_pc   <= RESET_PC;
      r_stale_addr <= RESET_PC;
    end else begin
      if (branch_taken) r_fetch_pc <= word_align(branch_address);
      else if (w_push)  r_fetch_pc <= r_fetch_pc + 32'(WordBytes);
      case (r_state)
        StRun: begin
          if (branch_taken && mem_req && !mem_ready) begin
            r_state      <= StDrain;
            r_stale_addr <= r_fetch_pc;
          end
        end
        StDrain: begin
          if (mem_ready) r_state <= StRun;
        end
        default: r_state <= StRun;
      endcase
    end
  end

  assign instruction = valid ? w_head.word : '0;
  assign pc          = valid ? (w_head.addr + 32'(WordBytes)) : '0;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with a wait-state memory model.
module tb_fetch_controller;

  localparam logic [31:0] ResetPc = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        mem_req;
  logic [31:0] mem_address;
  logic        mem_ready;
  logic [31:0] mem_instruction;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] pc;

  int unsigned mem_wait = 0;
  int unsigned mem_cnt  = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q [$];

  fetch_controller #(
    .BUF_DEPTH (2),
    .RESET_PC  (ResetPc)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_address  (branch_address),
    .mem_req         (mem_req),
    .mem_address     (mem_address),
    .mem_ready       (mem_ready),
    .mem_instruction (mem_instruction),
    .valid           (valid),
    .instruction     (instruction),
    .pc              (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory: ready after mem_wait cycles of a held request.
  assign mem_ready       = mem_req && (mem_cnt >= mem_wait);
  assign mem_instruction = mem_word(mem_address);
  always @(posedge clk) begin
    if (rst || mem_ready || !mem_req) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Expected pc p carries the word stored at p-4.
  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back({p, mem_word(p - 32'd4)});
  endtask

  // Monitor: every delivered (popped) instruction must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && !freeze && !branch_taken) begin
        if (exp_q.size() == 0) begin
          check32("unexpected_pc", pc, 32'hFFFF_FFFF);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check32("deliver_pc", pc, e[63:32]);
          check32("deliver_instr", instruction, e[31:0]);
        end
      end else if (!valid) begin
        check32("idle_zero", pc | instruction, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned w);
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    mem_wait = w;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check32("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check32("rst_valid", {31'd0, valid}, 32'd0);
    check32("rst_pc_instr", pc | instruction, 32'd0);
    check32("rst_mem_addr", mem_address, ResetPc);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    #1;
    check32("first_req", {31'd0, mem_req}, 32'd1);
    check32("first_addr", mem_address, ResetPc);
  endtask

  // Wait until every expected word has been delivered, then freeze to stop further pops.
  task automatic drain_expect(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step();
      cycles++;
    end
    if (exp_q.size() != 0) check32("drain_timeout", exp_q.size(), 32'd0);
    freeze = 1'b1;
  endtask

  task automatic wait_req_addr(input logic [31:0] a);
    int n;
    n = 0;
    while (!(mem_req && mem_address == a) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check32("wait_req_timeout", mem_address, a);
  endtask

  initial begin
    int cyc;

    // Zero-wait streaming: valid from cycle 2, one per cycle.
    do_reset(0);
    for (int i = 1; i <= 8; i++) expect_pc(32'(4 * i));
    release_reset();
    drain_expect(50, cyc);
    check32("stream_cycles", cyc, 32'd9);

    // Freeze for 4 cycles while pc=8 is presented.
    do_reset(0);
    for (int i = 1; i <= 6; i++) expect_pc(32'(4 * i));
    release_reset();
    step();
    step();
    check32("frz_start_pc", pc, 32'h8);
    freeze = 1'b1;
    #1;
    check32("frz_req_first", {31'd0, mem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check32("frz_hold_pc", pc, 32'h8);
      check32("frz_hold_instr", instruction, mem_word(32'h4));
      check32("frz_req_low", {31'd0, mem_req}, 32'd0);
    end
    step();
    freeze = 1'b0;
    drain_expect(50, cyc);

    // 3-wait memory, redirect to 0x90 one cycle into the 0x10 request.
    do_reset(3);
    expect_pc(32'h04); expect_pc(32'h08); expect_pc(32'h0C); expect_pc(32'h10);
    expect_pc(32'h94); expect_pc(32'h98);
    release_reset();
    wait_req_addr(32'h10);
    step();
    branch_taken = 1'b1;
    branch_address = 32'h90;
    step();
    branch_taken = 1'b0;
    check32("drain_req", {31'd0, mem_req}, 32'd1);
    check32("drain_addr0", mem_address, 32'h10);
    step();
    check32("drain_addr1", mem_address, 32'h10);
    check32("drain_ready", {31'd0, mem_ready}, 32'd1);
    step();
    check32("drain_target", mem_address, 32'h90);
    check32("drain_target_req", {31'd0, mem_req}, 32'd1);
    drain_expect(100, cyc);

    // Redirect to 0x40 in the same cycle as mem_ready.
    do_reset(0);
    expect_pc(32'h04); expect_pc(32'h44); expect_pc(32'h48);
    release_reset();
    step();
    step();
    branch_taken = 1'b1;
    branch_address = 32'h40;
    step();
    branch_taken = 1'b0;
    check32("coinc_addr", mem_address, 32'h40);
    check32("coinc_req", {31'd0, mem_req}, 32'd1);
    check32("coinc_valid", {31'd0, valid}, 32'd0);
    drain_expect(50, cyc);

    // Redirect to 0x43 while frozen with a full buffer.
    do_reset(0);
    expect_pc(32'h04); expect_pc(32'h44); expect_pc(32'h48);
    release_reset();
    step();
    step();
    freeze = 1'b1;
    step();
    check32("full_req_low", {31'd0, mem_req}, 32'd0);
    check32("full_pc", pc, 32'h8);
    branch_taken = 1'b1;
    branch_address = 32'h43;
    step();
    branch_taken = 1'b0;
    freeze = 1'b0;
    #1;
    check32("fbr_valid", {31'd0, valid}, 32'd0);
    check32("fbr_addr", mem_address, 32'h40);
    drain_expect(50, cyc);

    // Reset during DRAIN on the 0x4 request.
    do_reset(3);
    expect_pc(32'h04);
    release_reset();
    wait_req_addr(32'h4);
    step();
    branch_taken = 1'b1;
    branch_address = 32'h80;
    step();
    branch_taken = 1'b0;
    check32("rd_stale_addr", mem_address, 32'h4);
    check32("rd_queue_done", exp_q.size(), 32'd0);
    rst = 1'b1;
    #1;
    check32("rd_req_in_rst", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check32("rd_req_hold", {31'd0, mem_req}, 32'd0);
      check32("rd_valid_hold", {31'd0, valid}, 32'd0);
    end
    expect_pc(32'h04); expect_pc(32'h08);
    release_reset();
    drain_expect(100, cyc);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
